// File: rtl/fetch_queue_pkg.sv
// Shared pipeline constants for the fetch queue.
// Defaults and the NOP encoding used by fetch/decode.
package fetch_queue_pkg;
  localparam int FQ_DEPTH = 4;
  localparam int FQ_AW    = 32;
  localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle.
// slave is the queue side, master drives fetch/decode.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = FQ_AW
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [AW-1:0] in_pc;
  logic [AW-1:0] in_instr;
  logic          in_ready;
  logic          stall_pc;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pc_plus1;
  logic [AW-1:0] out_instr;
  logic          out_ready;
  logic          flush;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, in_pc, in_instr,
    input  out_ready, flush,
    output in_ready, stall_pc,
    output out_valid, out_pc,
    output out_pc_plus1, out_instr,
    output count
  );

  modport master (
    output in_valid, in_pc, in_instr,
    output out_ready, flush,
    input  in_ready, stall_pc,
    input  out_valid, out_pc,
    input  out_pc_plus1, out_instr,
    input  count
  );
endinterface

// File: rtl/fq_mem.sv
// Fetch queue entry storage: 1 write port,
// 1 asynchronous read port, no reset.
module fq_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [PW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [PW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between instruction fetch and decode.
// Pointer/count control; storage lives in fq_mem.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = FQ_AW
) (
  input  logic           clk,
  input  logic           rst,
  fetch_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [2*AW-1:0] w_rdata;
  logic [AW-1:0]   w_head_pc;

  // Flow control depends on registered count only.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.in_valid & ~w_full & ~bus.flush;
  assign w_pop   = bus.out_ready & ~w_empty & ~bus.flush;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  fq_mem #(
    .DEPTH (DEPTH),
    .W     (2*AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push & ~rst),
    .i_waddr (r_wptr),
    .i_wdata ({bus.in_pc, bus.in_instr}),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  assign w_head_pc        = w_rdata[2*AW-1:AW];
  assign bus.out_pc       = w_head_pc;
  assign bus.out_instr    = w_rdata[AW-1:0];
  assign bus.out_pc_plus1 = w_head_pc + AW'(1);
  assign bus.out_valid    = ~w_empty;
  assign bus.in_ready     = ~w_full;
  assign bus.stall_pc     = w_full;
  assign bus.count        = r_count;
endmodule
